pulse_train_gen: RTL
====================

Name: pulse_train_gen

Overview:
Parametrised successor to the single-shot pulse generator. On a start strobe it emits a programmable train of pulses with these settings:
- start delay
- high width
- rise-to-rise period
- pulse count, with continuous mode
- abort input
It also reports busy, done, error and progress status. It sits between the control/CSR logic and timing-critical outputs such as trigger lines and strobes.

Parameters:
CNT_W, 32, width of the delay, width and period counters and their inputs
NUM_W, 16, width of the pulse-count input and the progress counter
IDLE_LVL, 0, level of pulse_out when not in a high phase; the active level is ~IDLE_LVL
RETRIGGER, 0, 1 = start while busy restarts the train with new settings; 0 = start while busy is ignored

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle strobe, latches config and launches train
stop  in  1  one-cycle abort strobe
delay_in  in  CNT_W  cycles from start to first rising edge, beyond the fixed 1-cycle latency
width_in  in  CNT_W  high cycles per pulse; 0 is illegal
period_in  in  CNT_W  rise-to-rise cycles
count_in  in  NUM_W  number of pulses; 0 = continuous until stop
pulse_out  out  1  registered pulse output
busy_out  out  1  high from the cycle after an accepted start until the train ends
done_out  out  1  one-cycle strobe on normal completion
cfg_err_out  out  1  one-cycle strobe when a start is rejected
pulse_num_out  out  NUM_W  pulses started since the last accepted start

Behaviour:
- Reset (async assert, sync release):
  - FSM goes to IDLE.
  - pulse_out = IDLE_LVL.
  - busy_out, done_out, cfg_err_out = 0.
  - pulse_num_out = 0.
  - All latched config = 0.
- FSM states are IDLE, DELAY, HIGH, LOW. All outputs are registered.
- Accepting a start:
  - A start sampled in IDLE with width_in != 0 is accepted.
  - All four config inputs are latched; inputs are don't-care afterwards.
  - pulse_num_out clears to 0.
  - busy_out goes to 1 on the next edge.
- Rejected start: a start with width_in == 0 is rejected. cfg_err_out pulses for 1 cycle and the state is unchanged.
- Timing:
  - Start is sampled at edge T.
  - The first rising edge of pulse_out is at edge T+1+delay. With delay = 0, state goes directly to HIGH and no DELAY cycles occur.
  - Each pulse holds the active level for exactly width cycles.
  - pulse_num_out increments on each rising edge of pulse_out.
- Effective period = max(period, width+1). The low gap is never shorter than 1 cycle, so consecutive pulses never merge.
- After the final pulse (pulse_num == count, count != 0):
  - On the falling edge, go to IDLE directly; there is no trailing LOW phase.
  - done_out = 1 and busy_out = 0 on the same edge as the fall.
- Continuous mode (count == 0):
  - The train repeats until stop.
  - pulse_num_out wraps modulo 2^NUM_W.
- stop:
  - When sampled in any non-IDLE state, the next edge forces pulse_out = IDLE_LVL, busy_out = 0 and state = IDLE.
  - No done_out is asserted.
  - pulse_num_out holds its value.
  - stop in IDLE has no effect.
- start and stop sampled on the same edge: stop wins and start is dropped, including when in IDLE.
- start while busy:
  - RETRIGGER = 0: the start is ignored. No error is flagged.
  - RETRIGGER = 1: behaves as a fresh accepted start. Config is re-latched and pulse_num_out is cleared. pulse_out returns to IDLE_LVL on the next edge when delay > 0, or re-enters HIGH when delay = 0.
  - Retrigger with width_in == 0 is rejected via cfg_err_out, and the current train continues.
- Counters are CNT_W-bit down-counters loaded from the latched values; the terminal test is counter == 1. No arithmetic overflows: the width+1 compare is done in CNT_W+1 bits.
- Reset asserted mid-train: outputs go to their reset values immediately (asynchronously). No done_out is asserted.

Test Plan:
- Single pulse: delay=0, width=4, period=10, count=1, start at edge T:
  - pulse_out active on edges T+1..T+4, idle at T+5.
  - done_out and busy_out fall at T+5.
  - pulse_num_out = 1.
- Train: delay=3, width=2, period=5, count=3, start at T:
  - Rises at T+4, T+9 and T+14, each high for 2 cycles.
  - done_out at T+16.
  - pulse_num_out = 3.
- Period clamp: width=5, period=3, count=2 -> rises 6 cycles apart with a 1-cycle low gap.
- Error and abort:
  - width_in=0 start -> cfg_err_out for 1 cycle, busy_out stays 0.
  - count=0 continuous train, stop during HIGH -> pulse_out idle on the next edge, no done_out, pulse_num_out holds.
- Simultaneous and retrigger:
  - start+stop together in IDLE -> nothing launched.
  - RETRIGGER=1, start mid-LOW with width=7 -> pulse_num_out = 0, new 7-cycle pulses.
  - RETRIGGER=0, same stimulus -> the train continues unchanged.
- IDLE_LVL=1, mid-train reset: the bench forces reset low asynchronously between edges -> pulse_out = 1 and busy_out = 0 before the next clock edge.

Source files
------------

// File: rtl/pulse_train_gen.sv
// pulse_train_gen: programmable pulse train (delay, width, period, count/continuous) with abort, retrigger and status.
module pulse_train_gen #(
   parameter int CNT_W     = 32,
   parameter int NUM_W     = 16,
   parameter bit IDLE_LVL  = 1'b0,
   parameter bit RETRIGGER = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic [CNT_W-1:0] delay_in,
   input  logic [CNT_W-1:0] width_in,
   input  logic [CNT_W-1:0] period_in,
   input  logic [NUM_W-1:0] count_in,
   output logic             pulse_out,
   output logic             busy_out,
   output logic             done_out,
   output logic             cfg_err_out,
   output logic [NUM_W-1:0] pulse_num_out
);
   localparam logic [1:0] IDLE = 2'd0, DELAY = 2'd1, HIGH = 2'd2, LOW = 2'd3;
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
   logic [1:0]       state;
   logic             launch;
   logic [CNT_W-1:0] delay_q, width_q, period_q, cnt, low_len;
   logic [NUM_W-1:0] count_q;
   logic             allowed, accept, reject, last;
   always_comb begin
      allowed = RETRIGGER || (state == IDLE && !launch);
      accept  = start && !stop && allowed && width_in != '0;
      reject  = start && !stop && allowed && width_in == '0;
      last    = count_q != '0 && pulse_num_out == count_q;
      low_len = ({1'b0, period_q} > {1'b0, width_q}) ? period_q - width_q : ONE;
   end
   // an accepted start only latches config; the train launches on the following edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         launch        <= 1'b0;
         cnt           <= '0;
         delay_q       <= '0;
         width_q       <= '0;
         period_q      <= '0;
         count_q       <= '0;
         pulse_out     <= IDLE_LVL;
         busy_out      <= 1'b0;
         done_out      <= 1'b0;
         cfg_err_out   <= 1'b0;
         pulse_num_out <= '0;
      end else begin
         done_out    <= 1'b0;
         cfg_err_out <= reject;
         launch      <= accept;
         if (accept) begin
            delay_q  <= delay_in;
            width_q  <= width_in;
            period_q <= period_in;
            count_q  <= count_in;
         end
         if (stop && (state != IDLE || launch)) begin
            state     <= IDLE;
            pulse_out <= IDLE_LVL;
            busy_out  <= 1'b0;
         end else if (launch) begin
            busy_out      <= 1'b1;
            state         <= (delay_q == '0) ? HIGH : DELAY;
            cnt           <= (delay_q == '0) ? width_q : delay_q;
            pulse_out     <= (delay_q == '0) ? ~IDLE_LVL : IDLE_LVL;
            pulse_num_out <= (delay_q == '0) ? NUM_W'(1) : '0;
         end else if (state == HIGH) begin
            if (cnt == ONE) begin
               pulse_out <= IDLE_LVL;
               state     <= last ? IDLE : LOW;
               busy_out  <= !last;
               done_out  <= last;
               cnt       <= low_len;
            end else begin
               cnt <= cnt - ONE;
            end
         end else if (state != IDLE) begin
            if (cnt == ONE) begin
               state         <= HIGH;
               cnt           <= width_q;
               pulse_out     <= ~IDLE_LVL;
               pulse_num_out <= pulse_num_out + NUM_W'(1);
            end else begin
               cnt <= cnt - ONE;
            end
         end
      end
   end
endmodule
